// File: rtl/fp_sign_resolve_pipe.sv
// Sign resolution for FP add/sub/mul/div: effective op, swap, exact cancel and
// result sign, carried through an elastic STAGES-deep valid/ready pipeline.
module fp_sign_resolve_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic             SignX,
    input  logic             SignY,
    input  logic [EXP_W-1:0] ExpX,
    input  logic [EXP_W-1:0] ExpY,
    input  logic [MAN_W-1:0] ManX,
    input  logic [MAN_W-1:0] ManY,
    input  logic [1:0]       OpCode,
    input  logic [1:0]       RndMode,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             ResultSign,
    output logic             EffSub,
    output logic             Swap,
    output logic             ExactCancel
);
    localparam int MAG_W = EXP_W + MAN_W;

    // Payload bit order: {ResultSign, EffSub, Swap, ExactCancel}
    function automatic logic [3:0] resolveSign(
        input logic             signX,
        input logic             signY,
        input logic [MAG_W-1:0] magX,
        input logic [MAG_W-1:0] magY,
        input logic [1:0]       opCode,
        input logic [1:0]       rndMode
    );
        logic yEff;
        logic effSub;
        logic swap;
        logic cancel;
        logic sign;
        yEff   = signY ^ (opCode == 2'b01);
        effSub = signX ^ yEff;
        swap   = magY > magX;
        cancel = effSub && (magX == magY);
        if (!effSub)
            sign = signX;
        else if (swap)
            sign = yEff;
        else if (cancel)
            sign = (rndMode == 2'b11);
        else
            sign = signX;
        case (opCode)
            2'b00, 2'b01: resolveSign = {sign, effSub, swap, cancel};
            2'b10, 2'b11: resolveSign = {signX ^ signY, 3'b000};
            default:      resolveSign = 4'b0000;
        endcase
    endfunction

    logic [3:0]        inPayload_s;
    logic [STAGES-1:0] stageValid_r;
    logic [3:0]        stagePayload_r [STAGES];
    logic [STAGES-1:0] enable_s;
    logic [STAGES-1:0] srcValid_s;
    logic [3:0]        srcPayload_s [STAGES];

    // Resolve the sign fields of the incoming operation
    always_comb begin
        inPayload_s = resolveSign(SignX, SignY, {ExpX, ManX}, {ExpY, ManY}, OpCode, RndMode);
    end

    // A stage may load when it is empty or its occupant moves on this cycle
    always_comb begin
        enable_s = {STAGES{1'b0}};
        enable_s[STAGES-1] = ~stageValid_r[STAGES-1] | OutReady;
        for (int k = STAGES - 2; k >= 0; k--) begin
            enable_s[k] = ~stageValid_r[k] | enable_s[k+1];
        end
    end

    // Source of each stage: the input for stage 0, the previous stage otherwise
    always_comb begin
        srcValid_s = {STAGES{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                srcValid_s[k]   = InValid;
                srcPayload_s[k] = inPayload_s;
            end else begin
                srcValid_s[k]   = stageValid_r[k-1];
                srcPayload_s[k] = stagePayload_r[k-1];
            end
        end
    end

    // Stage registers; payload only changes when a real operation arrives
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stageValid_r <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                stagePayload_r[k] <= 4'b0000;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (enable_s[k]) begin
                    stageValid_r[k] <= srcValid_s[k];
                    if (srcValid_s[k]) begin
                        stagePayload_r[k] <= srcPayload_s[k];
                    end
                end
            end
        end
    end

    // Outputs come straight from the last stage registers
    always_comb begin
        InReady  = enable_s[0];
        OutValid = stageValid_r[STAGES-1];
        {ResultSign, EffSub, Swap, ExactCancel} = stagePayload_r[STAGES-1];
    end
endmodule

// File: tb/tb_fp_sign_resolve_pipe.sv
// Bench for fp_sign_resolve_pipe: directed vector table, backpressure and reset
// sequences, and randomized traffic checked by a scoreboard with a value-level model.
module tb_fp_sign_resolve_pipe;
    localparam int NV = 14;

    logic        Clk;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic        SignX;
    logic        SignY;
    logic [7:0]  ExpX;
    logic [7:0]  ExpY;
    logic [22:0] ManX;
    logic [22:0] ManY;
    logic [1:0]  OpCode;
    logic [1:0]  RndMode;
    logic        OutValid;
    logic        OutReady;
    logic        ResultSign;
    logic        EffSub;
    logic        Swap;
    logic        ExactCancel;

    int total = 0;
    int bad = 0;
    logic [3:0] expQ [$];

    typedef struct packed {
        logic        sx;
        logic        sy;
        logic [7:0]  ex;
        logic [7:0]  ey;
        logic [22:0] mx;
        logic [22:0] my;
        logic [1:0]  op;
        logic [1:0]  rm;
        logic [3:0]  expOut;
    } vec_t;

    vec_t vecs [NV];

    fp_sign_resolve_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(2)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .SignX(SignX), .SignY(SignY), .ExpX(ExpX), .ExpY(ExpY),
        .ManX(ManX), .ManY(ManY), .OpCode(OpCode), .RndMode(RndMode),
        .OutValid(OutValid), .OutReady(OutReady), .ResultSign(ResultSign),
        .EffSub(EffSub), .Swap(Swap), .ExactCancel(ExactCancel)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Value-level view: signed sum of +/-|X| and +/-|Y|; zero sign from rounding mode
    function automatic logic [3:0] refModel(input logic sx, input logic sy,
                                            input logic [7:0] ex, input logic [7:0] ey,
                                            input logic [22:0] mx, input logic [22:0] my,
                                            input logic [1:0] op, input logic [1:0] rm);
        longint magX;
        longint magY;
        logic ys;
        magX = (longint'(ex) << 23) + longint'(mx);
        magY = (longint'(ey) << 23) + longint'(my);
        if (op == 2'b10 || op == 2'b11) return {sx ^ sy, 3'b000};
        ys = (op == 2'b01) ? ~sy : sy;
        if (sx == ys) return {sx, 1'b0, magY > magX, 1'b0};
        if (magX > magY) return {sx, 3'b100};
        if (magY > magX) return {ys, 3'b110};
        return {rm == 2'b11, 3'b101};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Scoreboard: push model result on accept, compare in order on emit
    always @(negedge Clk) begin
        if (!Reset) begin
            if (OutValid && OutReady) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %b%b%b%b with no operation pending",
                             ResultSign, EffSub, Swap, ExactCancel);
                end else begin
                    check("scoreboard", 32'({ResultSign, EffSub, Swap, ExactCancel}),
                          32'(expQ.pop_front()));
                end
            end
            if (InValid && InReady)
                expQ.push_back(refModel(SignX, SignY, ExpX, ExpY, ManX, ManY, OpCode, RndMode));
        end
    end

    task automatic applyVec(input vec_t v);
        SignX = v.sx; SignY = v.sy; ExpX = v.ex; ExpY = v.ey;
        ManX = v.mx; ManY = v.my; OpCode = v.op; RndMode = v.rm;
    endtask

    task automatic randFields();
        SignX = 1'($urandom); SignY = 1'($urandom);
        ExpX = 8'($urandom);
        ExpY = ($urandom_range(0, 3) == 0) ? ExpX : 8'($urandom);
        ManX = 23'($urandom);
        ManY = ($urandom_range(0, 2) == 0) ? ManX : 23'($urandom);
        OpCode = 2'($urandom); RndMode = 2'($urandom);
    endtask

    // Issue one op on an idle pipe, then check its latency and payload
    task automatic runVec(input vec_t v, input string nm);
        int lat;
        int w;
        @(posedge Clk); #1;
        applyVec(v);
        InValid = 1'b1;
        w = 0;
        @(negedge Clk);
        while (!InReady && w < 20) begin
            @(negedge Clk);
            w++;
        end
        check({nm, "_accept"}, 32'(InReady), 32'd1);
        @(posedge Clk); #1;
        InValid = 1'b0;
        lat = 1;
        @(negedge Clk);
        while (!OutValid && lat < 10) begin
            @(negedge Clk);
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'd2);
        check({nm, "_payload"}, 32'({ResultSign, EffSub, Swap, ExactCancel}), 32'(v.expOut));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] hold;
        int idx;
        int w;
        hold = 4'b0000;
        // {sx, sy, ex, ey, mx, my, op, rm, {ResultSign, EffSub, Swap, ExactCancel}}
        vecs[0]  = '{1'b0, 1'b1, 8'h80, 8'h81, 23'h0, 23'h0, 2'b00, 2'b00, 4'b1110};
        vecs[1]  = '{1'b0, 1'b0, 8'h7F, 8'h7F, 23'h0, 23'h0, 2'b01, 2'b00, 4'b0101};
        vecs[2]  = '{1'b0, 1'b0, 8'h7F, 8'h7F, 23'h0, 23'h0, 2'b01, 2'b11, 4'b1101};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 23'h0, 23'h0, 2'b01, 2'b11, 4'b1101};
        vecs[4]  = '{1'b1, 1'b1, 8'h82, 8'h80, 23'h0, 23'h0, 2'b01, 2'b00, 4'b1100};
        vecs[5]  = '{1'b1, 1'b0, 8'h81, 8'h90, 23'h0, 23'h0, 2'b10, 2'b11, 4'b1000};
        vecs[6]  = '{1'b1, 1'b1, 8'h81, 8'h90, 23'h0, 23'h0, 2'b11, 2'b00, 4'b0000};
        vecs[7]  = '{1'b1, 1'b1, 8'h00, 8'h00, 23'h0, 23'h0, 2'b00, 2'b00, 4'b1000};
        vecs[8]  = '{1'b0, 1'b1, 8'h00, 8'h00, 23'h0, 23'h0, 2'b00, 2'b00, 4'b0101};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 8'h00, 23'h0, 23'h0, 2'b00, 2'b11, 4'b1101};
        vecs[10] = '{1'b0, 1'b0, 8'h10, 8'h20, 23'h0, 23'h0, 2'b00, 2'b00, 4'b0010};
        vecs[11] = '{1'b0, 1'b0, 8'h7F, 8'h7F, 23'h5, 23'h4, 2'b01, 2'b00, 4'b0100};
        vecs[12] = '{1'b0, 1'b0, 8'h7F, 8'h7F, 23'h5, 23'h6, 2'b01, 2'b00, 4'b1110};
        vecs[13] = '{1'b0, 1'b1, 8'h7F, 8'h7F, 23'h0, 23'h0, 2'b00, 2'b10, 4'b0101};

        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
        SignX = 1'b0; SignY = 1'b0; ExpX = 8'h00; ExpY = 8'h00;
        ManX = 23'h0; ManY = 23'h0; OpCode = 2'b00; RndMode = 2'b00;
        #12;
        check("reset_outvalid", 32'(OutValid), 32'd0);
        check("reset_payload", 32'({ResultSign, EffSub, Swap, ExactCancel}), 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("reset_inready", 32'(InReady), 32'd1);

        for (int i = 0; i < NV; i++) runVec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: 5 back-to-back ops, OutReady low for the first 4 cycles
        @(posedge Clk); #1;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            OutReady = (c >= 4);
            InValid = (idx < 5);
            if (idx < 5) randFields();
            @(negedge Clk);
            if (c == 2) begin
                check("bp_accepts", 32'(idx), 32'd2);
                check("bp_inready_low", 32'(InReady), 32'd0);
                check("bp_outvalid", 32'(OutValid), 32'd1);
                hold = {ResultSign, EffSub, Swap, ExactCancel};
            end
            if (c == 3) begin
                check("bp_inready_low2", 32'(InReady), 32'd0);
                check("bp_hold_valid", 32'(OutValid), 32'd1);
                check("bp_hold_payload", 32'({ResultSign, EffSub, Swap, ExactCancel}), 32'(hold));
            end
            if (c >= 4 && c <= 8) check($sformatf("bp_stream%0d", c), 32'(OutValid), 32'd1);
            if (InValid && InReady) idx++;
            @(posedge Clk); #1;
        end
        InValid = 1'b0;
        check("bp_all_accepted", 32'(idx), 32'd5);
        check("bp_drained", 32'(expQ.size()), 32'd0);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            InValid = ($urandom_range(0, 3) != 0);
            OutReady = ($urandom_range(0, 9) < 7);
            randFields();
            @(posedge Clk); #1;
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        w = 0;
        while (expQ.size() != 0 && w < 20) begin
            @(posedge Clk); #1;
            w++;
        end
        check("random_drained", 32'(expQ.size()), 32'd0);

        // Reset with two operations in flight
        randFields();
        InValid = 1'b1;
        @(posedge Clk); #1;
        randFields();
        @(posedge Clk); #1;
        InValid = 1'b0;
        check("prereset_valid", 32'(OutValid), 32'd1);
        Reset = 1'b1;
        expQ.delete();
        #1;
        check("midreset_outvalid", 32'(OutValid), 32'd0);
        check("midreset_payload", 32'({ResultSign, EffSub, Swap, ExactCancel}), 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("postreset_inready", 32'(InReady), 32'd1);
        check("postreset_outvalid", 32'(OutValid), 32'd0);
        runVec(vecs[4], "postreset");
        for (int c = 0; c < 8; c++) begin
            @(posedge Clk); #1;
        end
        check("postreset_empty", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_sign_resolve_pipe.md
Name: fp_sign_resolve_pipe

Overview:
- Pipelined, parametrised sign-resolution unit for the floating-point datapath.
- Accepts both operand signs, exponents and mantissas, plus the opcode and rounding mode.
- Computes the effective operation, operand swap and exact-cancellation flag internally, then produces the final result sign for add, sub, mul and div.
- Sits in parallel with the mantissa/exponent pipeline and has an elastic valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, mantissa (fraction) field width
- STAGES, 2, number of register stages; legal range 1..4

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- InValid  in  1  input operation valid
- InReady  out  1  unit can accept an operation this cycle
- SignX  in  1  sign of operand X
- SignY  in  1  sign of operand Y
- ExpX  in  EXP_W  biased exponent of X
- ExpY  in  EXP_W  biased exponent of Y
- ManX  in  MAN_W  fraction of X
- ManY  in  MAN_W  fraction of Y
- OpCode  in  2  00 add, 01 sub, 10 mul, 11 div
- RndMode  in  2  00 RNE, 01 RTZ, 10 RUP, 11 RDN
- OutValid  out  1  result valid
- OutReady  in  1  downstream accepts result
- ResultSign  out  1  final sign of result
- EffSub  out  1  effective subtraction (add/sub only)
- Swap  out  1  |Y| > |X| (add/sub only)
- ExactCancel  out  1  effective subtraction with |X| == |Y|

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
- Reset state: all stage valid bits clear. OutValid=0, ResultSign=0, EffSub=0, Swap=0, ExactCancel=0. InReady=1 on the first cycle after Reset deasserts.
- Accept: an operation is accepted on a cycle with InValid && InReady.
- Sign logic, evaluated combinationally before stage 1 and registered:
  - Sub = (OpCode==01). YEff = SignY ^ Sub.
  - Magnitude compare on {Exp,Man}, unsigned, width EXP_W+MAN_W.
  - Add/sub:
    - EffSub = SignX ^ YEff.
    - Swap = {ExpY,ManY} > {ExpX,ManX}.
    - ExactCancel = EffSub && magnitudes equal.
  - ResultSign for add/sub:
    - EffSub==0 -> SignX.
    - Swap -> YEff.
    - ExactCancel -> (RndMode==11); i.e. -0 only under RDN, +0 otherwise.
    - else -> SignX.
  - Mul/div: ResultSign = SignX ^ SignY; EffSub=Swap=ExactCancel=0. RndMode is ignored.
  - Zero and denormal operands need no special casing: the rules above already give (-0)+(-0)=-0, (+0)+(-0)=+0 (RNE) and (+0)+(-0)=-0 (RDN).
- Pipeline:
  - STAGES registered stages, each holding a valid bit and a payload {ResultSign, EffSub, Swap, ExactCancel}.
  - The last stage drives the outputs.
  - Stage k advances when its successor is empty or advancing; the last stage advances on OutReady.
  - InReady = ~valid[0] | advance[0]. It is combinational from OutReady through the chain.
- Latency and throughput: with OutReady held high, OutValid rises exactly STAGES cycles after the accept edge. Throughput is one operation per cycle.
- Backpressure:
  - While OutValid && !OutReady, all outputs hold stable.
  - Bubbles upstream collapse, so a full pipeline holds exactly STAGES operations.
  - Ordering is strictly FIFO. No drop, no duplicate.
- Full pipeline with OutReady=1: accept and emit happen in the same cycle, so InReady stays 1.
- Empty pipeline: OutValid=0. Output payload values are don't-care but must not toggle X in simulation.
- Reset mid-operation: all in-flight operations are discarded immediately and outputs return to reset values. No operation accepted before reset is ever emitted.
- STAGES=1: a single register stage with the same handshake rules.

Test Plan:
- Defaults for all scenarios: EXP_W=8, MAN_W=23, STAGES=2, OutReady=1 unless stated.
- Add mixed signs: SignX=0, ExpX=0x80, ManX=0; SignY=1, ExpY=0x81, ManY=0 -> EffSub=1, Swap=1, ResultSign=1, ExactCancel=0, OutValid 2 cycles after accept.
- Sub equal magnitudes: X=Y=+1.0 (Exp 0x7F, Man 0).
  - RndMode=00 -> ExactCancel=1, ResultSign=0.
  - Repeat with RndMode=11 -> ResultSign=1.
  - Repeat with X=+0, Y=+0 (all fields 0) under RDN -> ResultSign=1.
- Sub with larger X: SignX=1, ExpX=0x82; SignY=1, ExpY=0x80 -> EffSub=1, Swap=0, ResultSign=1.
- Mul/div: mul with SignX=1, SignY=0 -> ResultSign=1, EffSub=Swap=ExactCancel=0. Div with both signs 1 -> ResultSign=0.
- Backpressure: issue 5 back-to-back ops, hold OutReady=0 for 4 cycles.
  - InReady drops after 2 accepts; outputs stay stable.
  - After release, all 5 results emerge in order, one per cycle once flowing.
- Reset mid-flight: assert Reset with 2 ops in flight -> OutValid=0 in the same cycle. After release, none of those ops ever appear; a new op emerges after 2 cycles.
